// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/HOST arbiter for the single-port DataMem.
// Optional stats counters enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int WL        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [WL-1:0] cpu_addr,
  input  logic [WL-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [WL-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [WL-1:0] host_addr,
  input  logic [WL-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic [WL-1:0] host_rdata,
  output logic          host_rvalid,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]   cpu_wait_cnt,
  output logic [15:0]   host_gnt_cnt,
`endif
  output logic          DMWE,
  output logic [WL-1:0] DMA,
  output logic [WL-1:0] DMWD,
  input  logic [WL-1:0] DMRD
);

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } lock_e;

  lock_e         lock_q, lock_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  logic          last_owner_q, last_owner_d;
  logic [WL-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WL-1:0] host_rdata_q, host_rdata_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          host_rvalid_q, host_rvalid_d;

  // Grant selection: single requester wins, ties go to lock or round-robin
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (!RST) begin
      if (cpu_req && !host_req) begin
        cpu_gnt = 1'b1;
      end else if (host_req && !cpu_req) begin
        host_gnt = 1'b1;
      end else if (cpu_req && host_req) begin
        if (lock_q == LOCKED && burst_cnt_q < BMAX) begin
          host_gnt = 1'b1;
        end else if (last_owner_q) begin
          cpu_gnt = 1'b1;
        end else begin
          host_gnt = 1'b1;
        end
      end
    end
  end

  // DataMem port mux driven by the granted requester, zero when idle
  always_comb begin
    DMA  = '0;
    DMWD = '0;
    DMWE = 1'b0;
    if (host_gnt) begin
      DMA  = host_addr;
      DMWD = host_wdata;
      DMWE = host_we;
    end else if (cpu_gnt) begin
      DMA  = cpu_addr;
      DMWD = cpu_wdata;
      DMWE = cpu_we;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Response outputs; rvalid is masked while reset is held
  assign cpu_rdata   = cpu_rdata_q;
  assign host_rdata  = host_rdata_q;
  assign cpu_rvalid  = cpu_rvalid_q & ~RST;
  assign host_rvalid = host_rvalid_q & ~RST;

  // Next-state for ownership, lock FSM and read responses
  always_comb begin
    last_owner_d  = last_owner_q;
    lock_d        = lock_q;
    burst_cnt_d   = burst_cnt_q;
    cpu_rdata_d   = cpu_rdata_q;
    host_rdata_d  = host_rdata_q;
    cpu_rvalid_d  = cpu_gnt & ~cpu_we;
    host_rvalid_d = host_gnt & ~host_we;

    if (cpu_gnt)  last_owner_d = 1'b0;
    if (host_gnt) last_owner_d = 1'b1;

    if (cpu_rvalid_d)  cpu_rdata_d  = DMRD;
    if (host_rvalid_d) host_rdata_d = DMRD;

    unique case (lock_q)
      UNLOCKED: begin
        if (host_gnt && host_lock) begin
          lock_d      = LOCKED;
          burst_cnt_d = 4'd1;
        end
      end
      LOCKED: begin
        if (!host_lock || !host_req || cpu_gnt) begin
          lock_d      = UNLOCKED;
          burst_cnt_d = 4'd0;
        end else if (host_gnt) begin
          burst_cnt_d = (burst_cnt_q >= BMAX) ? BMAX
                                              : burst_cnt_q + 4'd1;
        end
      end
      default: begin
        lock_d      = UNLOCKED;
        burst_cnt_d = 4'd0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_owner_q  <= 1'b1;
      lock_q        <= UNLOCKED;
      burst_cnt_q   <= 4'd0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      last_owner_q  <= last_owner_d;
      lock_q        <= lock_d;
      burst_cnt_q   <= burst_cnt_d;
      cpu_rdata_q   <= cpu_rdata_d;
      host_rdata_q  <= host_rdata_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] cpu_wait_cnt_q, cpu_wait_cnt_d;
  logic [15:0] host_gnt_cnt_q, host_gnt_cnt_d;

  // Saturating stall and host-grant counters
  always_comb begin
    cpu_wait_cnt_d = cpu_wait_cnt_q;
    host_gnt_cnt_d = host_gnt_cnt_q;
    if (cpu_stall && cpu_wait_cnt_q != 16'hFFFF)
      cpu_wait_cnt_d = cpu_wait_cnt_q + 16'd1;
    if (host_gnt && host_gnt_cnt_q != 16'hFFFF)
      host_gnt_cnt_d = host_gnt_cnt_q + 16'd1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      cpu_wait_cnt_q <= '0;
      host_gnt_cnt_q <= '0;
    end else begin
      cpu_wait_cnt_q <= cpu_wait_cnt_d;
      host_gnt_cnt_q <= host_gnt_cnt_d;
    end
  end

  assign cpu_wait_cnt = cpu_wait_cnt_q;
  assign host_gnt_cnt = host_gnt_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a DataMem model
// and per-requester read-response scoreboards.
module tb_dmem_arbiter;
  localparam int WL = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cpu_req, cpu_we;
  logic [WL-1:0] cpu_addr, cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [WL-1:0] cpu_rdata;
  logic          host_req, host_we, host_lock;
  logic [WL-1:0] host_addr, host_wdata;
  logic          host_gnt, host_rvalid;
  logic [WL-1:0] host_rdata;
  logic          DMWE;
  logic [WL-1:0] DMA, DMWD, DMRD;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   cpu_wait_cnt, host_gnt_cnt;
`endif

  int total  = 0;
  int passed = 0;

  logic [WL-1:0] mem     [0:255];
  logic [WL-1:0] ref_mem [0:255];
  logic [WL-1:0] cpu_q[$];
  logic [WL-1:0] host_q[$];
  logic          pend_c = 1'b0;
  logic          pend_h = 1'b0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.WL(WL), .BURST_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
`ifdef DMEM_ARB_STATS_EN
    .cpu_wait_cnt(cpu_wait_cnt), .host_gnt_cnt(host_gnt_cnt),
`endif
    .DMWE(DMWE), .DMA(DMA), .DMWD(DMWD), .DMRD(DMRD)
  );

  assign DMRD = mem[DMA[7:0]];

  always @(posedge CLK) begin
    if (DMWE) mem[DMA[7:0]] <= DMWD;
  end

  task automatic chk(input string tag, input logic [WL-1:0] obs,
                     input logic [WL-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  // One clock cycle with expected grants; checks at the falling edge
  task automatic cyc(input logic ecg, input logic ehg, input string tag);
    logic [WL-1:0] e;
    logic [WL-1:0] ea;
    @(negedge CLK);
    chk({tag, ".cgnt"}, cpu_gnt, ecg);
    chk({tag, ".hgnt"}, host_gnt, ehg);
    chk({tag, ".stall"}, cpu_stall, cpu_req & ~ecg);
    chk({tag, ".dmwe"}, DMWE, (ecg & cpu_we) | (ehg & host_we));
    ea = ecg ? cpu_addr : (ehg ? host_addr : '0);
    chk({tag, ".dma"}, DMA, ea);
    chk({tag, ".crv"}, cpu_rvalid, pend_c & ~RST);
    chk({tag, ".hrv"}, host_rvalid, pend_h & ~RST);
    if (pend_c) begin
      if (cpu_q.size() == 0) chk({tag, ".cq_empty"}, 1, 0);
      else begin
        e = cpu_q.pop_front();
        if (!RST) chk({tag, ".crdata"}, cpu_rdata, e);
      end
    end
    if (pend_h) begin
      if (host_q.size() == 0) chk({tag, ".hq_empty"}, 1, 0);
      else begin
        e = host_q.pop_front();
        if (!RST) chk({tag, ".hrdata"}, host_rdata, e);
      end
    end
    pend_c = ecg & ~cpu_we;
    pend_h = ehg & ~host_we;
    if (pend_c) cpu_q.push_back(ref_mem[cpu_addr[7:0]]);
    if (pend_h) host_q.push_back(ref_mem[host_addr[7:0]]);
    if (ecg & cpu_we)  ref_mem[cpu_addr[7:0]]  = cpu_wdata;
    if (ehg & host_we) ref_mem[host_addr[7:0]] = host_wdata;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int k;
    logic hg;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    RST = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 32'd0; cpu_wdata = '0;
    host_req = 1'b1; host_we = 1'b0;
    host_addr = 32'd1; host_wdata = '0; host_lock = 1'b0;

    // reset with both requesting
    cyc(0, 0, "rst0");
    cyc(0, 0, "rst1");
    RST = 1'b0;
    chk("rst.crdata", cpu_rdata, 32'd0);
    chk("rst.hrdata", host_rdata, 32'd0);
    cyc(1, 0, "first_tie");

    // CPU store then load, host idle
    host_req = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'hDEADBEEF;
    cyc(1, 0, "cst");
    cpu_we = 1'b0;
    cyc(1, 0, "cld");
    cpu_req = 1'b0;
    cyc(0, 0, "cresp");
    chk("cld.value", cpu_rdata, 32'hDEADBEEF);

    // host-only read leaves HOST as last owner
    host_req = 1'b1; host_addr = 32'd5;
    cyc(0, 1, "hld");

    // round-robin contention
    cpu_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cpu_addr  = 32'(i);
      host_addr = 32'(i + 100);
      cyc((i % 2) == 0, (i % 2) == 1, $sformatf("rr%0d", i));
    end

    // CPU-only access so the burst starts with HOST winning the tie
    host_req = 1'b0; cpu_addr = 32'd5;
    cyc(1, 0, "pre_burst");

    // host burst lock: H H H H C H H
    host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      host_addr  = 32'(10 + k);
      host_wdata = 32'hA0 + 32'(k);
      hg = (i != 4);
      cyc(~hg, hg, $sformatf("burst%0d", i));
      if (hg) k++;
    end
    host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0; cpu_req = 1'b0;
    cyc(0, 0, "burst_drain");
    for (int i = 0; i < 6; i++)
      chk($sformatf("mem%0d", 10 + i), mem[10 + i], 32'hA0 + 32'(i));

    // reset in the response cycle of a locked host read
    host_req = 1'b1; host_lock = 1'b1; host_addr = 32'd12;
    cyc(0, 1, "hrd_lock");
    RST = 1'b1; cpu_req = 1'b1;
    cyc(0, 0, "rst_mid");
    RST = 1'b0;
    chk("rst_mid.hrdata", host_rdata, 32'd0);
    cyc(1, 0, "post_rst_tie");
    cpu_req = 1'b0;
    cyc(0, 1, "post_rst_h");
    host_req = 1'b0; host_lock = 1'b0;
    cyc(0, 0, "post_rst_drain");
    chk("post_rst.hval", host_rdata, 32'hA2);

    // contention from reset for the stats counters
    RST = 1'b1; cpu_req = 1'b1; host_req = 1'b1;
    cyc(0, 0, "st_rst");
    RST = 1'b0;
    for (int i = 0; i < 10; i++)
      cyc((i % 2) == 0, (i % 2) == 1, $sformatf("st%0d", i));
`ifdef DMEM_ARB_STATS_EN
    chk("stats.wait", 32'(cpu_wait_cnt), 32'd5);
    chk("stats.hgnt", 32'(host_gnt_cnt), 32'd5);
`endif
    cpu_req = 1'b0; host_req = 1'b0;
    cyc(0, 0, "final_drain");
    chk("cpu_q.left", 32'(cpu_q.size()), 32'd0);
    chk("host_q.left", 32'(host_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
